// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Package     : mips_pkg
// Description : Shared types and constants for the MIPS front end (fetch).
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

  // Fetch FSM: issue a request, then wait for its single response.
  typedef enum logic [0:0] {
    S_REQ  = 1'b0,
    S_WAIT = 1'b1
  } fetch_state_t;

  // PCSrcD encodings from decode; 2'b11 is handled like a branch.
  localparam logic [1:0] PCSRC_SEQ = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_JMP = 2'b10;

  // sll $0,$0,0 is the all-zero word.
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;

  // Redirect target: jumps splice the 28-bit jump field into the
  // upper nibble of the PC+4 held in IF/ID; everything else is a branch.
  function automatic logic [31:0] redirect_target(
    input logic [1:0]  pcsrc,
    input logic [31:0] branch_tgt,
    input logic [27:0] jump_field,
    input logic [3:0]  pc4_hi
  );
    logic [31:0] tgt;
    case (pcsrc)
      PCSRC_BR:  tgt = branch_tgt;
      PCSRC_JMP: tgt = {pc4_hi, jump_field};
      default:   tgt = branch_tgt;
    endcase
    return tgt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_skid_buf.sv
`default_nettype none
// ============================================================================
// Module      : fetch_skid_buf
// Description : One-entry {instr, pc4} holding register used when decode is
//               stalled while an instruction-memory response arrives.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_skid_buf
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load_i,
  input  logic        clear_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc4_i,
  output logic        buf_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc4_o
);

  logic        valid_q;
  logic [31:0] instr_q;
  logic [31:0] pc4_q;

  // Capture on load; clear (consume or squash) empties the entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR_DEFAULT;
      pc4_q   <= 32'h0;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      instr_q <= instr_i;
      pc4_q   <= pc4_i;
    end
  end

  assign buf_valid_o = valid_q;
  assign instr_o     = instr_q;
  assign pc4_o       = pc4_q;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : MIPS IF stage. Owns PCF, keeps one instruction-memory read
//               outstanding, and fills the IF/ID register, honouring decode
//               redirects and hazard-unit stalls.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushF,
  input  logic [1:0]  PCSrcD,
  input  logic [31:0] PCBranchD,
  input  logic [31:0] jumpdst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InstrD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pcf_q, pcf_d;
  logic         kill_q, kill_d;
  logic [31:0]  inflight_pc4_q, inflight_pc4_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  pcplus4_q, pcplus4_d;
  logic         valid_q, valid_d;

  logic         buf_valid;
  logic [31:0]  buf_instr;
  logic [31:0]  buf_pc4;
  logic         buf_load;
  logic         buf_clear;

  logic         redirect;
  logic         squash;
  logic [31:0]  target;
  logic         req;
  logic         handshake;
  logic         resp;
  logic         live;

  // Only the low 28 bits of the jump destination reach the PC.
  logic         unused_jumpdst_hi;
  assign unused_jumpdst_hi = ^jumpdst[31:28];

  // Request/response qualifiers and the redirect target mux.
  always_comb begin
    redirect  = (PCSrcD != PCSRC_SEQ) && !StallD;
    squash    = redirect || (FlushF && !StallD);
    target    = redirect_target(PCSrcD, PCBranchD, jumpdst[27:0], pcplus4_q[31:28]);
    req       = !reset && (state_q == S_REQ) && !StallF && !buf_valid;
    handshake = req && imem_gnt;
    resp      = (state_q == S_WAIT) && imem_rvalid;
    live      = resp && !kill_q;
  end

  // Fetch FSM, PC update and kill tracking for reads orphaned by a redirect.
  always_comb begin
    state_d        = state_q;
    pcf_d          = pcf_q;
    kill_d         = kill_q;
    inflight_pc4_d = inflight_pc4_q;

    case (state_q)
      S_REQ: begin
        if (handshake) begin
          inflight_pc4_d = pcf_q + 32'd4;
          pcf_d          = pcf_q + 32'd4;
          state_d        = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          state_d = S_REQ;
          kill_d  = 1'b0;
        end
      end
      default: state_d = S_REQ;
    endcase

    if (redirect) begin
      pcf_d = target;
      // A read that will still return after this edge belongs to the old path.
      if (((state_q == S_WAIT) && !imem_rvalid) || handshake) begin
        kill_d = 1'b1;
      end
    end
  end

  // IF/ID fill: stall parks live data in the skid buffer, squash inserts a
  // bubble, otherwise the buffered word wins over a live response.
  always_comb begin
    instr_d   = instr_q;
    pcplus4_d = pcplus4_q;
    valid_d   = valid_q;
    buf_load  = 1'b0;
    buf_clear = 1'b0;

    if (StallD) begin
      buf_load = live;
    end else if (squash) begin
      instr_d   = NOP_INSTR;
      valid_d   = 1'b0;
      buf_clear = 1'b1;
    end else if (buf_valid) begin
      instr_d   = buf_instr;
      pcplus4_d = buf_pc4;
      valid_d   = 1'b1;
      buf_clear = 1'b1;
    end else if (live) begin
      instr_d   = imem_rdata;
      pcplus4_d = inflight_pc4_q;
      valid_d   = 1'b1;
    end else begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end
  end

  // Fetch state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_REQ;
      pcf_q          <= RESET_PC;
      kill_q         <= 1'b0;
      inflight_pc4_q <= 32'h0;
    end else begin
      state_q        <= state_d;
      pcf_q          <= pcf_d;
      kill_q         <= kill_d;
      inflight_pc4_q <= inflight_pc4_d;
    end
  end

  // IF/ID pipeline register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_q   <= NOP_INSTR;
      pcplus4_q <= 32'h0;
      valid_q   <= 1'b0;
    end else begin
      instr_q   <= instr_d;
      pcplus4_q <= pcplus4_d;
      valid_q   <= valid_d;
    end
  end

  fetch_skid_buf u_skid (
    .clk         (clk),
    .reset       (reset),
    .load_i      (buf_load),
    .clear_i     (buf_clear),
    .instr_i     (imem_rdata),
    .pc4_i       (inflight_pc4_q),
    .buf_valid_o (buf_valid),
    .instr_o     (buf_instr),
    .pc4_o       (buf_pc4)
  );

  assign imem_req  = req;
  assign imem_addr = pcf_q;
  assign InstrD    = instr_q;
  assign PCPlus4D  = pcplus4_q;
  assign ValidD    = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Randomized bench for fetch_unit with a transaction-level
//               reference model and an IF/ID scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  localparam logic [31:0] C_NOP      = 32'h0000_0000;
  localparam logic [31:0] C_RESET_PC = 32'h0000_0000;
  localparam int          C_CYCLES   = 2000;

  logic        clk = 1'b0;
  logic        reset;
  logic        StallF, StallD, FlushF;
  logic [1:0]  PCSrcD;
  logic [31:0] PCBranchD, jumpdst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt, imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] InstrD, PCPlus4D;
  logic        ValidD;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(C_RESET_PC), .NOP_INSTR(C_NOP)) dut (
    .clk(clk), .reset(reset), .StallF(StallF), .StallD(StallD), .FlushF(FlushF),
    .PCSrcD(PCSrcD), .PCBranchD(PCBranchD), .jumpdst(jumpdst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .InstrD(InstrD), .PCPlus4D(PCPlus4D), .ValidD(ValidD)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction memory contents: low words hold a known addi, the rest a hash.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a < 32'h10) return 32'h2008_0005;
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  // ---------------- reference model (transaction level) ----------------
  typedef struct {
    logic        v;
    logic [31:0] instr;
    logic [31:0] pc4;
  } ifid_t;

  ifid_t       exp_q[$];
  logic        mon_en = 1'b0;

  logic [31:0] m_pc;
  logic        m_out;          // one read outstanding
  logic [31:0] m_out_addr;
  logic        m_out_killed;   // outstanding read belongs to a squashed path
  logic        m_buf_v;
  logic [31:0] m_buf_instr, m_buf_pc4;
  ifid_t       m_ifid;

  task automatic model_reset();
    m_pc         = C_RESET_PC;
    m_out        = 1'b0;
    m_out_addr   = '0;
    m_out_killed = 1'b0;
    m_buf_v      = 1'b0;
    m_buf_instr  = '0;
    m_buf_pc4    = '0;
    m_ifid.v     = 1'b0;
    m_ifid.instr = C_NOP;
    m_ifid.pc4   = '0;
  endtask

  // Advance the model across one rising edge using the inputs now applied.
  task automatic model_step();
    logic        exp_req, hs, resp, live, redirect, squash;
    logic [31:0] target;
    exp_req = !StallF && !m_out && !m_buf_v;
    check("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
    if (exp_req) check("imem_addr", imem_addr, m_pc);
    hs       = exp_req && imem_gnt;
    resp     = imem_rvalid && m_out;
    live     = resp && !m_out_killed;
    redirect = (PCSrcD != 2'b00) && !StallD;
    squash   = redirect || (FlushF && !StallD);
    if (PCSrcD == 2'b10) target = {m_ifid.pc4[31:28], jumpdst[27:0]};
    else                 target = PCBranchD;

    if (StallD) begin
      if (live) begin
        m_buf_v     = 1'b1;
        m_buf_instr = mem_word(m_out_addr);
        m_buf_pc4   = m_out_addr + 32'd4;
      end
    end else if (squash) begin
      m_ifid.v     = 1'b0;
      m_ifid.instr = C_NOP;
      m_buf_v      = 1'b0;
    end else if (m_buf_v) begin
      m_ifid.v     = 1'b1;
      m_ifid.instr = m_buf_instr;
      m_ifid.pc4   = m_buf_pc4;
      m_buf_v      = 1'b0;
    end else if (live) begin
      m_ifid.v     = 1'b1;
      m_ifid.instr = mem_word(m_out_addr);
      m_ifid.pc4   = m_out_addr + 32'd4;
    end else begin
      m_ifid.v     = 1'b0;
      m_ifid.instr = C_NOP;
    end

    if (resp) m_out = 1'b0;
    if (redirect && m_out) m_out_killed = 1'b1;
    if (hs) begin
      m_out        = 1'b1;
      m_out_addr   = m_pc;
      m_out_killed = redirect;
    end

    if (redirect) m_pc = target;
    else if (hs)  m_pc = m_pc + 32'd4;
  endtask

  // ---------------- monitor ----------------
  initial begin
    ifid_t e;
    forever begin
      @(negedge clk);
      if (mon_en && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("ValidD", {31'b0, ValidD}, {31'b0, e.v});
        if (e.v) begin
          check("InstrD", InstrD, e.instr);
          check("PCPlus4D", PCPlus4D, e.pc4);
        end else begin
          check("InstrD_bubble", InstrD, C_NOP);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int  rst_hold;
    int  rst_done;
    logic in_reset, stale;
    ifid_t rst_e;
    rst_hold = 0;
    rst_done = 0;
    reset = 1'b1;
    StallF = 1'b0; StallD = 1'b0; FlushF = 1'b0; PCSrcD = 2'b00;
    PCBranchD = '0; jumpdst = '0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    model_reset();
    #1;
    check("reset_req", {31'b0, imem_req}, 32'd0);
    check("reset_ValidD", {31'b0, ValidD}, 32'd0);
    check("reset_InstrD", InstrD, C_NOP);
    check("reset_PCPlus4D", PCPlus4D, 32'd0);
    repeat (2) @(negedge clk);

    for (int cyc = 0; cyc < C_CYCLES; cyc++) begin
      @(negedge clk);
      in_reset = 1'b0;
      if (rst_hold > 0) begin
        rst_hold--;
        in_reset = 1'b1;
      end else if (cyc > 30 && m_out && rst_done < 3 && ($urandom % 40) == 0) begin
        rst_hold = 2;
        rst_done++;
        in_reset = 1'b1;
      end
      stale = reset && !in_reset;

      if (cyc < 12) begin
        // Zero-wait memory, no hazards.
        StallF = 1'b0; StallD = 1'b0; PCSrcD = 2'b00; FlushF = 1'b0;
        imem_gnt = 1'b1;
        imem_rvalid = m_out;
      end else begin
        StallF   = ($urandom % 5) == 0;
        StallD   = ($urandom % 4) == 0;
        imem_gnt = ($urandom % 3) != 0;
        if (m_out) imem_rvalid = ($urandom % 2) == 0;
        else       imem_rvalid = ($urandom % 16) == 0;
        PCSrcD   = (($urandom % 10) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        FlushF   = (PCSrcD != 2'b00) || (($urandom % 25) == 0);
      end
      PCBranchD = {$urandom, 2'b00} >> 0;
      PCBranchD[1:0] = 2'b00;
      jumpdst   = {4'b0000, 26'($urandom), 2'b00};
      if (stale) imem_rvalid = 1'b1;
      imem_rdata = (imem_rvalid && m_out) ? mem_word(m_out_addr) : $urandom;
      reset = in_reset;

      #1;
      if (in_reset) begin
        check("rst_req", {31'b0, imem_req}, 32'd0);
        check("rst_ValidD", {31'b0, ValidD}, 32'd0);
        check("rst_InstrD", InstrD, C_NOP);
        check("rst_PCPlus4D", PCPlus4D, 32'd0);
        model_reset();
        rst_e.v = 1'b0; rst_e.instr = C_NOP; rst_e.pc4 = '0;
        exp_q.push_back(rst_e);
      end else begin
        model_step();
        exp_q.push_back(m_ifid);
      end
      mon_en = 1'b1;
    end

    repeat (2) @(negedge clk);
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
